// File: rtl/ps2_key_event_rx.sv
// PS/2 keyboard receiver: oversampled and filtered line capture, 11-bit frame
// validation, E0/F0 prefix folding into key events, and a first-word-fall-through
// event FIFO with a digit decode of the head entry.
module ps2_key_event_rx #(
  parameter int CLK_DIV       = 4,
  parameter int FILTER_LEN    = 8,
  parameter int FIFO_DEPTH    = 8,
  parameter int TIMEOUT_TICKS = 50000
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          ps2_clk,
  input  logic                          ps2_data,
  input  logic                          rd_en,
  output logic                          key_valid,
  output logic [7:0]                    key_code,
  output logic                          key_ext,
  output logic                          key_break,
  output logic [3:0]                    key_digit,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          overflow,
  output logic                          frame_err
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int TO_W  = $clog2(TIMEOUT_TICKS + 1);
  localparam int AW    = $clog2(FIFO_DEPTH);
  localparam int CW    = AW + 1;

  typedef enum logic [1:0] {S_IDLE, S_DATA, S_PARITY, S_STOP} state_t;

  // Scan code to digit/key value; non-digit keys map to 4'hF.
  function automatic logic [3:0] digit_decode(input logic [7:0] code);
    case (code)
      8'h45:   digit_decode = 4'h0;
      8'h16:   digit_decode = 4'h1;
      8'h1E:   digit_decode = 4'h2;
      8'h26:   digit_decode = 4'h3;
      8'h25:   digit_decode = 4'h4;
      8'h2E:   digit_decode = 4'h5;
      8'h36:   digit_decode = 4'h6;
      8'h3D:   digit_decode = 4'h7;
      8'h3E:   digit_decode = 4'h8;
      8'h46:   digit_decode = 4'h9;
      8'h5A:   digit_decode = 4'hB;
      8'h0D:   digit_decode = 4'hC;
      default: digit_decode = 4'hF;
    endcase
  endfunction

  logic [DIV_W-1:0]      div_cnt;
  logic                  tick;
  logic                  clk_p0, clk_p1, dat_p0, dat_p1;
  logic [FILTER_LEN-1:0] clk_hist, dat_hist;
  logic                  clk_filt, dat_filt, clk_filt_d;
  logic                  fall;

  state_t                state, state_nxt;
  logic                  start_en, shift_en, par_en, stop_en;
  logic [2:0]            bit_idx;
  logic [7:0]            shift_p0;
  logic                  par_p0;
  logic [TO_W-1:0]       to_cnt;
  logic                  timeout_hit;
  logic                  frame_good, frame_bad;
  logic                  ext_flag, brk_flag;

  logic                  vld_p0;
  logic [9:0]            evt_p0;

  logic [9:0]            mem [FIFO_DEPTH];
  logic [AW-1:0]         wr_ptr, rd_ptr;
  logic [CW-1:0]         count;
  logic                  full, empty, do_pop, do_push;
  logic [9:0]            head;

  assign tick = (div_cnt == DIV_W'(CLK_DIV - 1));

  // Sample-tick divider.
  always_ff @(posedge clk) begin
    if (rst) div_cnt <= '0;
    else     div_cnt <= tick ? '0 : div_cnt + 1'b1;
  end

  // Two-flop synchronisers; idle level of both lines is 1.
  always_ff @(posedge clk) begin
    if (rst) begin
      clk_p0 <= 1'b1;
      clk_p1 <= 1'b1;
      dat_p0 <= 1'b1;
      dat_p1 <= 1'b1;
    end else begin
      clk_p0 <= ps2_clk;
      clk_p1 <= clk_p0;
      dat_p0 <= ps2_data;
      dat_p1 <= dat_p0;
    end
  end

  // Tick-sampled histories; a filtered level moves only on a unanimous history.
  always_ff @(posedge clk) begin
    if (rst) begin
      clk_hist   <= '1;
      dat_hist   <= '1;
      clk_filt   <= 1'b1;
      dat_filt   <= 1'b1;
      clk_filt_d <= 1'b1;
    end else begin
      clk_filt_d <= clk_filt;
      if (tick) begin
        clk_hist <= {clk_hist[FILTER_LEN-2:0], clk_p1};
        dat_hist <= {dat_hist[FILTER_LEN-2:0], dat_p1};
      end
      if (&clk_hist)       clk_filt <= 1'b1;
      else if (~|clk_hist) clk_filt <= 1'b0;
      if (&dat_hist)       dat_filt <= 1'b1;
      else if (~|dat_hist) dat_filt <= 1'b0;
    end
  end

  assign fall        = clk_filt_d & ~clk_filt;
  assign timeout_hit = (state != S_IDLE) && tick && !fall &&
                       (to_cnt == TO_W'(TIMEOUT_TICKS - 1));

  // Frame state register.
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Frame next-state and per-bit strobes, advancing on each filtered clock fall.
  always_comb begin
    state_nxt = state;
    start_en  = 1'b0;
    shift_en  = 1'b0;
    par_en    = 1'b0;
    stop_en   = 1'b0;
    if (timeout_hit) begin
      state_nxt = S_IDLE;
    end else if (fall) begin
      case (state)
        S_IDLE: begin
          if (!dat_filt) begin
            start_en  = 1'b1;
            state_nxt = S_DATA;
          end
        end
        S_DATA: begin
          shift_en = 1'b1;
          if (bit_idx == 3'd7) state_nxt = S_PARITY;
        end
        S_PARITY: begin
          par_en    = 1'b1;
          state_nxt = S_STOP;
        end
        S_STOP: begin
          stop_en   = 1'b1;
          state_nxt = S_IDLE;
        end
        default: state_nxt = S_IDLE;
      endcase
    end
  end

  assign frame_good = stop_en & dat_filt & (^shift_p0 ^ par_p0);
  assign frame_bad  = stop_en & ~frame_good;

  // Bit index and inactivity counter for the frame in progress.
  always_ff @(posedge clk) begin
    if (rst) begin
      bit_idx <= '0;
      to_cnt  <= '0;
    end else begin
      if (start_en)      bit_idx <= '0;
      else if (shift_en) bit_idx <= bit_idx + 1'b1;
      if (state == S_IDLE || fall || timeout_hit) to_cnt <= '0;
      else if (tick)                              to_cnt <= to_cnt + 1'b1;
    end
  end

  // LSB-first data shift and parity capture.
  always_ff @(posedge clk) begin
    if (shift_en) shift_p0 <= {dat_filt, shift_p0[7:1]};
    if (par_en)   par_p0   <= dat_filt;
  end

  // Prefix folding, event strobe and error pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      ext_flag  <= 1'b0;
      brk_flag  <= 1'b0;
      vld_p0    <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      vld_p0    <= 1'b0;
      frame_err <= 1'b0;
      if (timeout_hit || frame_bad) begin
        ext_flag  <= 1'b0;
        brk_flag  <= 1'b0;
        frame_err <= 1'b1;
      end else if (frame_good) begin
        if (shift_p0 == 8'hE0) begin
          ext_flag <= 1'b1;
        end else if (shift_p0 == 8'hF0) begin
          brk_flag <= 1'b1;
        end else begin
          vld_p0   <= 1'b1;
          ext_flag <= 1'b0;
          brk_flag <= 1'b0;
        end
      end
    end
  end

  // Event payload captured alongside its strobe.
  always_ff @(posedge clk) begin
    if (frame_good) evt_p0 <= {ext_flag, brk_flag, shift_p0};
  end

  assign full    = (count == CW'(FIFO_DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = rd_en & ~empty;
  assign do_push = vld_p0 & (~full | do_pop);

  // Event storage.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= evt_p0;
  end

  // FIFO pointers, occupancy and sticky overflow.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (vld_p0 & full & ~do_pop) overflow <= 1'b1;
    end
  end

  assign head       = mem[rd_ptr];
  assign key_valid  = ~empty;
  assign key_code   = empty ? 8'h00 : head[7:0];
  assign key_break  = ~empty & head[8];
  assign key_ext    = ~empty & head[9];
  assign key_digit  = (empty | head[9] | head[8]) ? 4'hF : digit_decode(head[7:0]);
  assign fifo_count = count;

endmodule

// File: tb/tb_ps2_key_event_rx.sv
// Bench for ps2_key_event_rx: directed PS/2 frames, expected events queued at
// stimulus time and compared by a monitor whenever an event is popped.
module tb_ps2_key_event_rx;

  localparam int CLK_DIV       = 2;
  localparam int FILTER_LEN    = 4;
  localparam int FIFO_DEPTH    = 8;
  localparam int TIMEOUT_TICKS = 200;
  localparam int H             = 20;   // half bit period in clk cycles
  localparam int GAP           = 40;

  logic       clk = 1'b0;
  logic       rst, ps2_clk, ps2_data, rd_en;
  logic       key_valid, key_ext, key_break, overflow, frame_err;
  logic [7:0] key_code;
  logic [3:0] key_digit;
  logic [3:0] fifo_count;

  typedef struct packed {
    logic       ext;
    logic       brk;
    logic [7:0] code;
    logic [3:0] digit;
  } evt_t;

  evt_t exp_q[$];
  evt_t mon_e;
  int   checks   = 0;
  int   failures = 0;
  int   err_cnt  = 0;
  int   err_base;

  ps2_key_event_rx #(
    .CLK_DIV(CLK_DIV), .FILTER_LEN(FILTER_LEN),
    .FIFO_DEPTH(FIFO_DEPTH), .TIMEOUT_TICKS(TIMEOUT_TICKS)
  ) dut (
    .clk(clk), .rst(rst), .ps2_clk(ps2_clk), .ps2_data(ps2_data), .rd_en(rd_en),
    .key_valid(key_valid), .key_code(key_code), .key_ext(key_ext),
    .key_break(key_break), .key_digit(key_digit), .fifo_count(fifo_count),
    .overflow(overflow), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  // Monitor: count error pulses and compare every popped head entry.
  always @(negedge clk) begin
    if (frame_err === 1'b1) err_cnt++;
    if (rst === 1'b0 && rd_en === 1'b1 && key_valid === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL pop_unexpected: got code=%02h ext=%0b brk=%0b, no event required",
                 key_code, key_ext, key_break);
      end else begin
        mon_e = exp_q.pop_front();
        if ({key_ext, key_break, key_code, key_digit} !== mon_e) begin
          failures++;
          $display("FAIL pop_event: got ext=%0b brk=%0b code=%02h digit=%0h, required ext=%0b brk=%0b code=%02h digit=%0h",
                   key_ext, key_break, key_code, key_digit,
                   mon_e.ext, mon_e.brk, mon_e.code, mon_e.digit);
        end
      end
    end
  end

  initial begin
    #600us;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic exp_push(input logic ext, input logic brk, input logic [7:0] code,
                          input logic [3:0] digit);
    evt_t e;
    e.ext = ext; e.brk = brk; e.code = code; e.digit = digit;
    exp_q.push_back(e);
  endtask

  function automatic logic [10:0] make_frame(input logic [7:0] b, input bit par_ok,
                                             input bit stop_ok);
    logic p;
    p = ~^b;
    if (!par_ok) p = ~p;
    return {stop_ok ? 1'b1 : 1'b0, p, b, 1'b0};
  endfunction

  task automatic send_bits(input logic [10:0] f, input int n);
    for (int i = 0; i < n; i++) begin
      ps2_data = f[i];
      cyc(H);
      ps2_clk = 1'b0;
      cyc(H);
      ps2_clk = 1'b1;
    end
    ps2_data = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] b, input bit par_ok = 1'b1,
                            input bit stop_ok = 1'b1);
    send_bits(make_frame(b, par_ok, stop_ok), 11);
    cyc(GAP);
  endtask

  task automatic pop_one();
    int n;
    n = 0;
    while (key_valid !== 1'b1 && n < 200) begin
      cyc(1);
      n++;
    end
    if (key_valid !== 1'b1) begin
      checks++;
      failures++;
      $display("FAIL pop_wait: key_valid=%0b, required 1", key_valid);
    end
    rd_en = 1'b1;
    cyc(1);
    rd_en = 1'b0;
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_valid"},  key_valid,  0);
    check({tag, "_code"},   key_code,   0);
    check({tag, "_ext"},    key_ext,    0);
    check({tag, "_break"},  key_break,  0);
    check({tag, "_digit"},  key_digit,  4'hF);
    check({tag, "_count"},  fifo_count, 0);
    check({tag, "_ovf"},    overflow,   0);
    check({tag, "_ferr"},   frame_err,  0);
  endtask

  initial begin
    rst = 1'b1; ps2_clk = 1'b1; ps2_data = 1'b1; rd_en = 1'b0;
    cyc(3);
    check_reset("reset");
    rst = 1'b0;
    cyc(20);

    // Single 0x16 frame, then pop.
    exp_push(1'b0, 1'b0, 8'h16, 4'h1);
    send_frame(8'h16);
    check("t1_valid", key_valid, 1);
    check("t1_code",  key_code,  8'h16);
    check("t1_ext",   key_ext,   0);
    check("t1_break", key_break, 0);
    check("t1_digit", key_digit, 4'h1);
    check("t1_count", fifo_count, 1);
    pop_one();
    check("t1_valid_after", key_valid, 0);
    check("t1_count_after", fifo_count, 0);
    rd_en = 1'b1; cyc(1); rd_en = 1'b0;
    check("empty_pop_count", fifo_count, 0);

    // Break and extended-break sequences.
    err_base = err_cnt;
    exp_push(1'b0, 1'b1, 8'h45, 4'hF);
    exp_push(1'b1, 1'b1, 8'h75, 4'hF);
    send_frame(8'hF0); send_frame(8'h45);
    send_frame(8'hE0); send_frame(8'hF0); send_frame(8'h75);
    check("t2_count", fifo_count, 2);
    check("t2_ferr",  err_cnt - err_base, 0);
    pop_one(); pop_one();
    check("t2_count_after", fifo_count, 0);

    // Bad parity clears pending prefix; bad stop bit is also rejected.
    err_base = err_cnt;
    send_frame(8'hF0);
    send_frame(8'h1E, 1'b0, 1'b1);
    check("t3_ferr_parity", err_cnt - err_base, 1);
    exp_push(1'b0, 1'b0, 8'h26, 4'h3);
    send_frame(8'h26);
    check("t3_count", fifo_count, 1);
    pop_one();
    send_frame(8'h16, 1'b1, 1'b0);
    check("t3_ferr_stop", err_cnt - err_base, 2);
    check("t3_count_stop", fifo_count, 0);

    // Decode of extended, Enter, Tab and a non-digit key.
    exp_push(1'b1, 1'b0, 8'h45, 4'hF);
    exp_push(1'b0, 1'b0, 8'h5A, 4'hB);
    exp_push(1'b0, 1'b0, 8'h0D, 4'hC);
    exp_push(1'b0, 1'b0, 8'h1C, 4'hF);
    send_frame(8'hE0); send_frame(8'h45);
    send_frame(8'h5A); send_frame(8'h0D); send_frame(8'h1C);
    check("t4_count", fifo_count, 4);
    repeat (4) pop_one();

    // Fill to full, push with a simultaneous pop, then overflow.
    begin
      logic [7:0] codes [8];
      codes = '{8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D, 8'h3E};
      for (int i = 0; i < 8; i++) begin
        exp_push(1'b0, 1'b0, codes[i], 4'(i + 1));
        send_frame(codes[i]);
      end
    end
    check("full_count", fifo_count, 8);
    check("full_ovf",   overflow,   0);
    exp_push(1'b0, 1'b0, 8'h46, 4'h9);
    fork
      send_frame(8'h46);
      begin
        int n;
        n = 0;
        while (dut.vld_p0 !== 1'b1 && n < 2000) begin
          @(posedge clk); #1;
          n++;
        end
        if (n >= 2000) begin
          checks++;
          failures++;
          $display("FAIL push_wait: event strobe not seen, required within 2000 cycles");
        end
        rd_en = 1'b1;
        cyc(1);
        rd_en = 1'b0;
      end
    join
    check("pushpop_count", fifo_count, 8);
    check("pushpop_ovf",   overflow,   0);
    send_frame(8'h45); send_frame(8'h5A);
    check("ovf_count", fifo_count, 8);
    check("ovf_flag",  overflow,   1);
    repeat (8) pop_one();
    check("drain_count", fifo_count, 0);
    check("ovf_sticky",  overflow,   1);

    // Inactivity timeout mid-frame, then a clean frame.
    err_base = err_cnt;
    send_bits(make_frame(8'h55, 1'b1, 1'b1), 6);
    cyc(2 * CLK_DIV * TIMEOUT_TICKS + 300);
    check("timeout_ferr", err_cnt - err_base, 1);
    exp_push(1'b0, 1'b0, 8'h3E, 4'h8);
    send_frame(8'h3E);
    check("timeout_next_count", fifo_count, 1);
    pop_one();

    // Reset with three queued entries and a partial frame in progress.
    send_frame(8'h16); send_frame(8'h1E); send_frame(8'h26);
    check("pre_rst_count", fifo_count, 3);
    send_bits(make_frame(8'h36, 1'b1, 1'b1), 3);
    rst = 1'b1;
    cyc(1);
    check_reset("midrst");
    rst = 1'b0;
    cyc(10);

    // One-tick glitch on ps2_clk must not disturb anything.
    err_base = err_cnt;
    ps2_clk = 1'b0;
    cyc(CLK_DIV);
    ps2_clk = 1'b1;
    cyc(100);
    check("glitch_valid", key_valid, 0);
    check("glitch_count", fifo_count, 0);
    check("glitch_ferr",  err_cnt - err_base, 0);
    exp_push(1'b0, 1'b0, 8'h45, 4'h0);
    send_frame(8'h45);
    check("post_rst_count", fifo_count, 1);
    pop_one();
    check("final_count", fifo_count, 0);
    check("final_queue", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
